// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control with HALT.
// Define MULTICYCLE_SEQUENCER_RETIRE_CNT_EN to add the saturating instr_count output.
module multicycle_sequencer #(
    parameter int unsigned LAST_PC   = 20,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        done,
    output logic        illegal
`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StHalt
    } state_e;

    localparam logic [5:0]  OpRtype  = 6'h00;
    localparam logic [5:0]  OpLw     = 6'h23;
    localparam logic [5:0]  OpSw     = 6'h2B;
    localparam logic [31:0] LastPcW  = 32'(LAST_PC);
    localparam logic [31:0] LastWord = 32'(MEM_DEPTH - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        retire;
    logic [5:0]  opcode;

    assign opcode = ir_q[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        done_d    = done_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                if_en   = 1'b1;
                ir_d    = instruction;
                state_d = StDecode;
            end
            StDecode: begin
                id_en = 1'b1;
                if (opcode == OpRtype || opcode == OpLw || opcode == OpSw) begin
                    state_d = StExecute;
                end else begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StExecute: begin
                ex_en = 1'b1;
                if (!stall) begin
                    state_d = (opcode == OpRtype) ? StWriteback : StMemory;
                end
            end
            StMemory: begin
                mem_en = 1'b1;
                if (!stall) begin
                    if (opcode == OpLw) begin
                        state_d = StWriteback;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            StWriteback: begin
                wb_en  = 1'b1;
                retire = 1'b1;
            end
            StHalt: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Completion takes priority over the end-of-memory overrun check.
        if (retire) begin
            if (pc_q == LastPcW) begin
                state_d = StHalt;
                done_d  = 1'b1;
            end else if (pc_q == LastWord) begin
                state_d   = StHalt;
                illegal_d = 1'b1;
            end else begin
                state_d = StFetch;
                pc_d    = pc_q + 32'd1;
            end
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign done    = done_q;
    assign illegal = illegal_q;

`ifdef MULTICYCLE_SEQUENCER_RETIRE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire && cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_count = cnt_q;
`endif

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter LAST_PC, default 20, meaning word index of the final program instruction.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning instruction memory depth in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, level sampled in IDLE to begin execution.
REQ-006 SHALL have port stall, input, 1, datapath busy; holds the EXECUTE or MEMORY phase.
REQ-007 SHALL have port instruction, input, 32, combinational read data from instruction memory at pc.
REQ-008 SHALL have port pc, output, 32, word index driven to instruction memory.
REQ-009 SHALL have port ir, output, 32, latched instruction register.
REQ-010 SHALL have ports if_en, id_en, ex_en, mem_en, wb_en, output, 1 each, one-hot phase enables; all 0 in IDLE/HALT.
REQ-011 SHALL have port done, output, 1, high while in HALT after normal completion.
REQ-012 SHALL have port illegal, output, 1, high while in HALT after an unsupported opcode or PC overrun.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-014 IDLE: start=1 -> FETCH with pc=0; start=0 -> stay.
REQ-015 FETCH: if_en=1; ir <= instruction at the FETCH edge; -> DECODE next cycle.
REQ-016 DECODE: id_en=1; opcode = ir[31:26]; 000000 (R-type), 100011 (lw), 101011 (sw) -> EXECUTE; any other opcode -> HALT with illegal=1.
REQ-017 EXECUTE: ex_en=1; stall=1 -> stay; else lw/sw -> MEMORY, R-type -> WRITEBACK.
REQ-018 MEMORY: mem_en=1; stall=1 -> stay; else lw -> WRITEBACK, sw -> retire.
REQ-019 WRITEBACK: wb_en=1, exactly one cycle, then retire.
REQ-020 Retire: if pc==LAST_PC -> HALT with done=1; else pc <= pc+1 and -> FETCH.
REQ-021 Instruction latency with stall=0: R-type 4 cycles, sw 4 cycles, lw 5 cycles, FETCH to the next FETCH.
REQ-022 pc increments only on retire, by 1 word; if pc==MEM_DEPTH-1 retires with LAST_PC not reached -> HALT with illegal=1, no wrap to 0.
REQ-023 HALT: pc and ir hold; done/illegal hold; leaves only via rst_n.
REQ-024 start is ignored in every state other than IDLE.
REQ-025 stall is ignored in FETCH, DECODE, and WRITEBACK.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, pc=0, ir=0, all enables 0, done=0, illegal=0, regardless of current phase.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction; no retire or pc increment SHALL follow deassertion.
REQ-028 After rst_n rises, the first FETCH SHALL occur no earlier than the cycle after start is sampled high.

Configuration
REQ-029 With macro MULTICYCLE_SEQUENCER_RETIRE_CNT_EN defined, SHALL add output instr_count, 32 bits, reset to 0, incremented by 1 on each retire, saturating at 32'hFFFFFFFF, held in HALT.
REQ-030 Without MULTICYCLE_SEQUENCER_RETIRE_CNT_EN, instr_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Program of 8 lw (idx 0-7) + 13 R-type (idx 8-20), LAST_PC=20, stall=0, start pulse -> done=1 after 8*5+13*4=92 cycles from the first FETCH; pc=20; illegal=0.
REQ-032 lw at idx 0, stall=1 for 3 cycles entering EXECUTE -> ex_en high 4 cycles; then MEMORY and WRITEBACK; pc=1 at the next FETCH.
REQ-033 Word 32'hFC000000 at idx 2 -> HALT after DECODE of idx 2 with illegal=1, done=0, pc=2.
REQ-034 rst_n pulsed low during MEMORY of idx 5 -> state IDLE, pc=0 in the same cycle; restart re-executes from idx 0.
REQ-035 MEM_DEPTH=4, LAST_PC=20, four R-type words -> HALT with illegal=1 at pc=3.
REQ-036 With MULTICYCLE_SEQUENCER_RETIRE_CNT_EN defined, program of REQ-031 -> instr_count=21 at done.
